fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 21 ++
 rtl/fetch_buf.sv | 106 ++++++++++
 rtl/fetch_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_REDIR = 2'd2
   } state_e;

   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h6;
   localparam logic [3:0] OP_BNE = 4'hE;
   localparam logic [3:0] OP_NOP = 4'hF;

   localparam logic [15:0] NOP_WORD = {OP_NOP, 12'h000};

   localparam int unsigned BUF_DEPTH   = 2;
   localparam int unsigned BUF_CNT_W   = 2;
   localparam int unsigned FETCH_CNT_W = 8;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry instruction buffer; the head registers feed decode directly
// and read as a NOP at PC 0 whenever the buffer is empty.
module fetch_buf
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned PC_W = 6,
   parameter int unsigned IW   = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 push_i,
   input  logic                 pop_i,
   input  logic                 flush_i,
   input  logic [IW-1:0]        push_instr_i,
   input  logic [PC_W-1:0]      push_pc_i,
   output logic [BUF_CNT_W-1:0] count_o,
   output logic [IW-1:0]        head_instr_o,
   output logic [PC_W-1:0]      head_pc_o
);

   logic [BUF_CNT_W-1:0] cnt_q, cnt_d;
   logic [IW-1:0]        head_instr_q, head_instr_d;
   logic [PC_W-1:0]      head_pc_q, head_pc_d;
   logic [IW-1:0]        tail_instr_q, tail_instr_d;
   logic [PC_W-1:0]      tail_pc_q, tail_pc_d;
   logic                 pop_ok;
   logic                 full;
   logic                 empty;

   assign empty  = (cnt_q == '0);
   assign full   = (cnt_q == BUF_CNT_W'(BUF_DEPTH));
   assign pop_ok = pop_i && !empty;

   // Next buffer contents; a flush wins over any push or pop
   always_comb begin
      cnt_d        = cnt_q;
      head_instr_d = head_instr_q;
      head_pc_d    = head_pc_q;
      tail_instr_d = tail_instr_q;
      tail_pc_d    = tail_pc_q;
      if (flush_i) begin
         cnt_d        = '0;
         head_instr_d = IW'(NOP_WORD);
         head_pc_d    = '0;
      end else begin
         case ({push_i, pop_ok})
            2'b11: begin
               if (full) begin
                  head_instr_d = tail_instr_q;
                  head_pc_d    = tail_pc_q;
                  tail_instr_d = push_instr_i;
                  tail_pc_d    = push_pc_i;
               end else begin
                  head_instr_d = push_instr_i;
                  head_pc_d    = push_pc_i;
               end
            end
            2'b01: begin
               cnt_d = cnt_q - BUF_CNT_W'(1);
               if (full) begin
                  head_instr_d = tail_instr_q;
                  head_pc_d    = tail_pc_q;
               end else begin
                  head_instr_d = IW'(NOP_WORD);
                  head_pc_d    = '0;
               end
            end
            2'b10: begin
               if (!full) begin
                  cnt_d = cnt_q + BUF_CNT_W'(1);
                  if (empty) begin
                     head_instr_d = push_instr_i;
                     head_pc_d    = push_pc_i;
                  end else begin
                     tail_instr_d = push_instr_i;
                     tail_pc_d    = push_pc_i;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q        <= '0;
         head_instr_q <= IW'(NOP_WORD);
         head_pc_q    <= '0;
         tail_instr_q <= IW'(NOP_WORD);
         tail_pc_q    <= '0;
      end else begin
         cnt_q        <= cnt_d;
         head_instr_q <= head_instr_d;
         head_pc_q    <= head_pc_d;
         tail_instr_q <= tail_instr_d;
         tail_pc_q    <= tail_pc_d;
      end
   end

   assign count_o      = cnt_q;
   assign head_instr_o = head_instr_q;
   assign head_pc_o    = head_pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequential PC, branch redirect with a
// one-cycle bubble, and a two-entry buffer toward decode.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned PC_W     = 6,
   parameter int unsigned IW       = 16,
   parameter int unsigned RESET_PC = 0
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   EN,
   output logic [PC_W-1:0]        PCI,
   input  logic [IW-1:0]          INSTR,
   input  logic                   BR_TAKEN,
   input  logic [PC_W-1:0]        BR_TARGET,
   output logic [IW-1:0]          IR,
   output logic [PC_W-1:0]        IR_PC,
   output logic                   IR_VALID,
   input  logic                   IR_READY,
   output logic [FETCH_CNT_W-1:0] FETCH_CNT
);

   state_e                 state_q, state_d;
   logic [PC_W-1:0]        pc_q, pc_d;
   logic [FETCH_CNT_W-1:0] fcnt_q, fcnt_d;
   logic [BUF_CNT_W-1:0]   buf_cnt;
   logic                   xfer_c;
   logic                   push_c;
   logic                   pop_c;
   logic                   flush_c;
   logic                   room_c;

   // State register
   always_ff @(posedge CLK) begin
      if (RST) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next state; a branch redirect overrides everything else
   always_comb begin
      state_d = state_q;
      if (BR_TAKEN) begin
         state_d = ST_REDIR;
      end else begin
         case (state_q)
            ST_IDLE:  state_d = EN ? ST_FETCH : ST_IDLE;
            ST_FETCH: state_d = EN ? ST_FETCH : ST_IDLE;
            ST_REDIR: state_d = EN ? ST_FETCH : ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Buffer control and PC / counter next values
   always_comb begin
      xfer_c  = IR_VALID && IR_READY;
      room_c  = (buf_cnt < BUF_CNT_W'(BUF_DEPTH)) || xfer_c;
      flush_c = BR_TAKEN;
      pop_c   = xfer_c && !BR_TAKEN;
      push_c  = (state_q == ST_FETCH) && EN && !BR_TAKEN && room_c;
      pc_d    = pc_q;
      fcnt_d  = fcnt_q;
      if (BR_TAKEN) begin
         pc_d = BR_TARGET;
      end else if (push_c) begin
         pc_d = pc_q + PC_W'(1);
      end
      if (push_c) begin
         fcnt_d = fcnt_q + FETCH_CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         pc_q   <= PC_W'(RESET_PC);
         fcnt_q <= '0;
      end else begin
         pc_q   <= pc_d;
         fcnt_q <= fcnt_d;
      end
   end

   fetch_buf #(
      .PC_W (PC_W),
      .IW   (IW)
   ) u_buf (
      .clk_i        (CLK),
      .rst_i        (RST),
      .push_i       (push_c),
      .pop_i        (pop_c),
      .flush_i      (flush_c),
      .push_instr_i (INSTR),
      .push_pc_i    (pc_q),
      .count_o      (buf_cnt),
      .head_instr_o (IR),
      .head_pc_o    (IR_PC)
   );

   assign PCI       = pc_q;
   assign IR_VALID  = (buf_cnt != '0);
   assign FETCH_CNT = fcnt_q;

endmodule
